// File: rtl/odometer_meas_ctrl.sv
// ---------------------------------------------------------------------------
// odometer_meas_ctrl
//   Measurement sequencer for the odometer. A MEAS_REQ pulse raises
//   MEAS_STRESS, waits for the stressed oscillator to settle, counts
//   synchronized rising edges of ROSC_IN over a fixed gate window, then
//   raises MEAS_DONE so EN_ROSC is dropped before MEAS_STRESS falls. The
//   result is offered on COUNT/OVERFLOW with a COUNT_VALID/COUNT_ACK handshake.
//
// Ports
//   CLK          in   system clock
//   RESETn       in   asynchronous active-low reset
//   MEAS_REQ     in   one-cycle measurement request
//   ROSC_IN      in   divided ROSC output, asynchronous to CLK
//   COUNT_ACK    in   consumer accepts COUNT
//   MEAS_STRESS  out  measurement phase active (to power_enable)
//   MEAS_DONE    out  measurement finished, gates EN_ROSC off
//   BUSY         out  sequencer not idle
//   COUNT        out  rising-edge count of the last window
//   COUNT_VALID  out  COUNT holds an unacknowledged result
//   OVERFLOW     out  edge counter saturated in the last window
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for an acceptable MEAS_REQ
// SETTLE | MEAS_STRESS up, oscillator settling, edges ignored
// GATE   | gate window open, synchronized edges counted
// DONE   | MEAS_DONE up with MEAS_STRESS still up, result latched
// ---------------------------------------------------------------------------
module odometer_meas_ctrl #(
   parameter int CNT_W      = 16,
   parameter int WIN_CYC    = 1024,
   parameter int SETTLE_CYC = 16,
   parameter int DONE_CYC   = 2
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             MEAS_REQ,
   input  logic             ROSC_IN,
   input  logic             COUNT_ACK,
   output logic             MEAS_STRESS,
   output logic             MEAS_DONE,
   output logic             BUSY,
   output logic [CNT_W-1:0] COUNT,
   output logic             COUNT_VALID,
   output logic             OVERFLOW
);

   localparam int MAX_A   = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
   localparam int MAX_CYC = (MAX_A > DONE_CYC) ? MAX_A : DONE_CYC;
   localparam int TMR_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GATE   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state_q;
   logic [TMR_W-1:0]   tmr_q;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               ovf_q,   ovf_d;
   logic               rosc_s1_q, rosc_s2_q, rosc_s3_q;
   logic               stress_q, done_q, busy_q, valid_q, overflow_q;
   logic [CNT_W-1:0]   count_q;
   logic               rosc_edge;
   logic               start;

   assign rosc_edge = rosc_s2_q & ~rosc_s3_q;

   // An ack in the same cycle as the request retires the old result, so the
   // request is only refused while a result is pending and not being taken.
   assign start = MEAS_REQ & (~valid_q | COUNT_ACK);

   // Next counter value including an edge seen this cycle; the window-close
   // transfer uses this so an edge in the last gate cycle is still counted.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if ((state_q == GATE) && rosc_edge) begin
         if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         rosc_s1_q  <= 1'b0;
         rosc_s2_q  <= 1'b0;
         rosc_s3_q  <= 1'b0;
         stress_q   <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         rosc_s1_q <= ROSC_IN;
         rosc_s2_q <= rosc_s1_q;
         rosc_s3_q <= rosc_s2_q;

         if (COUNT_ACK && valid_q) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= SETTLE;
                  stress_q <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  ovf_q    <= 1'b0;
                  tmr_q    <= TMR_W'(SETTLE_CYC - 1);
               end
            end
            SETTLE: begin
               if (tmr_q == '0) begin
                  state_q <= GATE;
                  tmr_q   <= TMR_W'(WIN_CYC - 1);
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            GATE: begin
               cnt_q <= cnt_d;
               ovf_q <= ovf_d;
               if (tmr_q == '0) begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  count_q    <= cnt_d;
                  overflow_q <= ovf_d;
                  valid_q    <= 1'b1;
                  tmr_q      <= TMR_W'(DONE_CYC - 1);
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            DONE: begin
               if (tmr_q == '0) begin
                  state_q  <= IDLE;
                  stress_q <= 1'b0;
                  done_q   <= 1'b0;
                  busy_q   <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign MEAS_STRESS = stress_q;
   assign MEAS_DONE   = done_q;
   assign BUSY        = busy_q;
   assign COUNT       = count_q;
   assign COUNT_VALID = valid_q;
   assign OVERFLOW    = overflow_q;

endmodule
